// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbiter states, port owner and the memory request
// bundle used by both masters and the memory side.
package dmem_arb_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 9;
  localparam logic [2:0]  FUNCT3_WORD = 3'b010;

  typedef enum logic {
    CORE_PRI,
    EXT_FORCE
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_EXT
  } owner_e;

  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the MEM stage, the ext debug/loader master, the data memory and the
// arbiter. The arbiter takes the slave view; the surrounding system drives the master view.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9
) ();

  logic                  core_rd;
  logic                  core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_funct3;
  logic                  core_stall;
  logic [DATA_W-1:0]     core_rdata;

  logic                  ext_req;
  logic                  ext_we;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_funct3,
    output core_stall, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_funct3,
    input  core_stall, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_req_mux.sv
// Owner-select mux onto the memory port. With no owner the core fields still pass through so
// the address/data lines stay quiet, but both strobes are forced low.
module dmem_req_mux
  import dmem_arb_pkg::*;
(
  input  owner_e    owner_i,
  input  dmem_req_t core_req_i,
  input  dmem_req_t ext_req_i,
  output dmem_req_t mem_req_o
);

  always_comb begin
    mem_req_o = core_req_i;
    unique case (owner_i)
      OWN_CORE: mem_req_o = core_req_i;
      OWN_EXT:  mem_req_o = ext_req_i;
      default: begin
        mem_req_o.rd = 1'b0;
        mem_req_o.wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and an ext master, with a
// starvation counter that steals one cycle from the core after MAX_WAIT blocked ext cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter int unsigned DM_ADDRESS = DMEM_ADDR_W,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned CNT_W      = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  // The request struct has fixed widths; refuse to elaborate against a mismatched bus.
  if (DATA_W != DMEM_DATA_W || DM_ADDRESS != DMEM_ADDR_W) begin : g_width_chk
    $error("dmem_arbiter: bus widths must match dmem_arb_pkg");
  end

  arb_state_e        state_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic              ext_rvalid_q;
  logic [DATA_W-1:0] ext_rdata_q;

  logic      core_act;
  logic      contested;
  logic      at_limit;
  logic      ext_gnt;
  owner_e    owner;
  dmem_req_t core_req;
  dmem_req_t ext_req;
  dmem_req_t mem_req;

  assign core_act  = bus.core_rd | bus.core_wr;
  assign contested = (state_q == CORE_PRI) & core_act & bus.ext_req;
  assign at_limit  = (wcnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    owner = OWN_NONE;
    if (state_q == EXT_FORCE) begin
      if (bus.ext_req) owner = OWN_EXT;
    end else if (core_act) begin
      owner = OWN_CORE;
    end else if (bus.ext_req) begin
      owner = OWN_EXT;
    end
  end

  assign ext_gnt = (owner == OWN_EXT);

  assign core_req = '{rd:     bus.core_rd,
                      wr:     bus.core_wr,
                      addr:   bus.core_addr,
                      wdata:  bus.core_wdata,
                      funct3: bus.core_funct3};

  assign ext_req  = '{rd:     ~bus.ext_we,
                      wr:     bus.ext_we,
                      addr:   bus.ext_addr,
                      wdata:  bus.ext_wdata,
                      funct3: FUNCT3_WORD};

  dmem_req_mux u_req_mux (
    .owner_i    (owner),
    .core_req_i (core_req),
    .ext_req_i  (ext_req),
    .mem_req_o  (mem_req)
  );

  // Forced slot lasts exactly one cycle; any non-contested cycle clears the wait count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CORE_PRI;
      wcnt_q       <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q <= CORE_PRI;
      wcnt_q  <= '0;
      if (contested) begin
        if (at_limit) state_q <= EXT_FORCE;
        else          wcnt_q  <= wcnt_q + CNT_W'(1);
      end
      ext_rvalid_q <= ext_gnt & ~bus.ext_we;
      if (ext_gnt & ~bus.ext_we) ext_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.ext_gnt    = ext_gnt;
  assign bus.core_stall = (state_q == EXT_FORCE) & core_act;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.mem_rd     = mem_req.rd;
  assign bus.mem_wr     = mem_req.wr;
  assign bus.mem_addr   = mem_req.addr;
  assign bus.mem_wdata  = mem_req.wdata;
  assign bus.mem_funct3 = mem_req.funct3;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_WAIT 4 and 1) share one stimulus stream and are
// compared every cycle against a denial-streak model, plus directed literal expectations.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned MW0 = 4;
  localparam int unsigned MW1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_rd, core_wr, ext_req, ext_we;
  logic [8:0]  core_addr, ext_addr;
  logic [31:0] core_wdata, ext_wdata;
  logic [2:0]  core_funct3;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus0 ();
  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus1 ();

  assign bus0.core_rd = core_rd;     assign bus1.core_rd = core_rd;
  assign bus0.core_wr = core_wr;     assign bus1.core_wr = core_wr;
  assign bus0.core_addr = core_addr; assign bus1.core_addr = core_addr;
  assign bus0.core_wdata = core_wdata;
  assign bus1.core_wdata = core_wdata;
  assign bus0.core_funct3 = core_funct3;
  assign bus1.core_funct3 = core_funct3;
  assign bus0.ext_req = ext_req;     assign bus1.ext_req = ext_req;
  assign bus0.ext_we = ext_we;       assign bus1.ext_we = ext_we;
  assign bus0.ext_addr = ext_addr;   assign bus1.ext_addr = ext_addr;
  assign bus0.ext_wdata = ext_wdata; assign bus1.ext_wdata = ext_wdata;

  // Memory instances behind each arbiter: combinational read, write at the edge.
  logic [31:0] tmem0 [128];
  logic [31:0] tmem1 [128];
  assign bus0.mem_rdata = tmem0[bus0.mem_addr[8:2]];
  assign bus1.mem_rdata = tmem1[bus1.mem_addr[8:2]];
  always @(posedge clk) if (bus0.mem_wr) tmem0[bus0.mem_addr[8:2]] <= bus0.mem_wdata;
  always @(posedge clk) if (bus1.mem_wr) tmem1[bus1.mem_addr[8:2]] <= bus1.mem_wdata;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(MW0), .CNT_W(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(MW1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference model: count consecutive denied ext cycles; once the count hits MAX_WAIT the
  // following cycle belongs to ext outright.
  typedef struct packed {
    logic        rd, wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        gnt, stall;
    logic [31:0] crdata;
    logic        rvalid;
    logic [31:0] rdata;
  } obs_t;

  int unsigned streak     [2];
  bit          force_now  [2];
  logic [31:0] mmem       [2][128];
  logic        exp_rvalid [2];
  logic [31:0] exp_rdata  [2];

  function automatic int unsigned mw(int i);
    return (i == 0) ? MW0 : MW1;
  endfunction

  function automatic obs_t model_out(int i);
    obs_t e;
    logic act, own_core, own_ext;
    act      = core_rd | core_wr;
    own_core = act && !force_now[i];
    own_ext  = ext_req && (force_now[i] || !act);
    e.gnt    = own_ext;
    e.stall  = force_now[i] && act;
    e.rd     = own_core ? core_rd : (own_ext ? !ext_we : 1'b0);
    e.wr     = own_core ? core_wr : (own_ext ? ext_we : 1'b0);
    e.addr   = own_ext ? ext_addr : core_addr;
    e.wdata  = own_ext ? ext_wdata : core_wdata;
    e.funct3 = own_ext ? 3'b010 : core_funct3;
    e.crdata = mmem[i][e.addr[8:2]];
    e.rvalid = exp_rvalid[i];
    e.rdata  = exp_rdata[i];
    return e;
  endfunction

  function automatic obs_t dut_out(int i);
    obs_t d;
    if (i == 0) begin
      d = '{rd: bus0.mem_rd, wr: bus0.mem_wr, addr: bus0.mem_addr, wdata: bus0.mem_wdata,
            funct3: bus0.mem_funct3, gnt: bus0.ext_gnt, stall: bus0.core_stall,
            crdata: bus0.core_rdata, rvalid: bus0.ext_rvalid, rdata: bus0.ext_rdata};
    end else begin
      d = '{rd: bus1.mem_rd, wr: bus1.mem_wr, addr: bus1.mem_addr, wdata: bus1.mem_wdata,
            funct3: bus1.mem_funct3, gnt: bus1.ext_gnt, stall: bus1.core_stall,
            crdata: bus1.core_rdata, rvalid: bus1.ext_rvalid, rdata: bus1.ext_rdata};
    end
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      obs_t e;
      e = model_out(i);
      if (reset) begin
        exp_rvalid[i] = 1'b0;
        exp_rdata[i]  = '0;
      end else if (e.gnt && !ext_we) begin
        exp_rvalid[i] = 1'b1;
        exp_rdata[i]  = mmem[i][ext_addr[8:2]];
      end else begin
        exp_rvalid[i] = 1'b0;
      end
      if (e.wr) mmem[i][e.addr[8:2]] = e.wdata;
      if (reset || force_now[i]) begin
        streak[i]    = 0;
        force_now[i] = 1'b0;
      end else if (ext_req && (core_rd || core_wr)) begin
        streak[i] = streak[i] + 1;
        if (streak[i] >= mw(i)) begin
          force_now[i] = 1'b1;
          streak[i]    = 0;
        end
      end else begin
        streak[i] = 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        obs_t e, d;
        e = model_out(i);
        d = dut_out(i);
        cmp($sformatf("d%0d ext_gnt", i), 32'(d.gnt), 32'(e.gnt));
        cmp($sformatf("d%0d core_stall", i), 32'(d.stall), 32'(e.stall));
        cmp($sformatf("d%0d mem_rd", i), 32'(d.rd), 32'(e.rd));
        cmp($sformatf("d%0d mem_wr", i), 32'(d.wr), 32'(e.wr));
        cmp($sformatf("d%0d mem_addr", i), 32'(d.addr), 32'(e.addr));
        cmp($sformatf("d%0d mem_wdata", i), d.wdata, e.wdata);
        cmp($sformatf("d%0d mem_funct3", i), 32'(d.funct3), 32'(e.funct3));
        cmp($sformatf("d%0d core_rdata", i), d.crdata, e.crdata);
        cmp($sformatf("d%0d ext_rvalid", i), 32'(d.rvalid), 32'(e.rvalid));
        cmp($sformatf("d%0d ext_rdata", i), d.rdata, e.rdata);
      end
    end
  end

  task automatic set_idle();
    core_rd = 1'b0;
    core_wr = 1'b0;
    ext_req = 1'b0;
    ext_we  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    set_idle();
    next_cycle();
  endtask

  task automatic contend_read();
    core_rd   = 1'b1;
    core_wr   = 1'b0;
    core_addr = 9'h010;
    ext_req   = 1'b1;
    ext_we    = 1'b0;
    ext_addr  = 9'h020;
  endtask

  logic [5:0] g0_exp, g1_exp, s1_exp, v1_exp;

  initial begin
    reset = 1'b1;
    set_idle();
    core_addr   = '0;
    core_wdata  = '0;
    core_funct3 = 3'b010;
    ext_addr    = '0;
    ext_wdata   = '0;
    for (int k = 0; k < 128; k++) begin
      tmem0[k] = '0; tmem1[k] = '0; mmem[0][k] = '0; mmem[1][k] = '0;
    end
    tmem0[4] = 32'hDEADBEEF; tmem1[4] = 32'hDEADBEEF;
    mmem[0][4] = 32'hDEADBEEF; mmem[1][4] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      streak[i] = 0; force_now[i] = 1'b0; exp_rvalid[i] = 1'b0; exp_rdata[i] = '0;
    end

    next_cycle();
    chk_en = 1'b1;
    next_cycle();

    // Plain core load straight out of reset.
    reset   = 1'b0;
    core_rd = 1'b1;
    core_addr = 9'h010;
    @(negedge clk);
    cmp("reset core_stall", 32'(bus0.core_stall), 32'd0);
    cmp("reset ext_gnt", 32'(bus0.ext_gnt), 32'd0);
    cmp("reset ext_rvalid", 32'(bus0.ext_rvalid), 32'd0);
    cmp("reset ext_rdata", bus0.ext_rdata, 32'h0);
    cmp("core load rdata", bus0.core_rdata, 32'hDEADBEEF);
    next_cycle();

    // Uncontested ext write then read-back.
    set_idle();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h020; ext_wdata = 32'h12345678;
    @(negedge clk);
    cmp("ext write gnt", 32'(bus0.ext_gnt), 32'd1);
    cmp("ext write mem_wr", 32'(bus0.mem_wr), 32'd1);
    next_cycle();
    ext_we = 1'b0;
    @(negedge clk);
    cmp("ext read gnt", 32'(bus1.ext_gnt), 32'd1);
    cmp("ext read funct3", 32'(bus0.mem_funct3), 32'd2);
    next_cycle();
    set_idle();
    @(negedge clk);
    cmp("ext read rvalid", 32'(bus0.ext_rvalid), 32'd1);
    cmp("ext read rdata", bus0.ext_rdata, 32'h12345678);
    next_cycle();

    // Core writes every cycle against a held ext write: starvation forcing.
    g0_exp = 6'b010000; g1_exp = 6'b001010; s1_exp = 6'b101010;
    core_wr = 1'b1; core_addr = 9'h040; core_wdata = 32'hA5A50000;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h024; ext_wdata = 32'h0BADF00D;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) ext_req = 1'b0;
      @(negedge clk);
      cmp($sformatf("starve mw4 gnt c%0d", c), 32'(bus0.ext_gnt), 32'(g0_exp[c]));
      cmp($sformatf("starve mw4 stall c%0d", c), 32'(bus0.core_stall), 32'(g0_exp[c]));
      cmp($sformatf("starve mw1 gnt c%0d", c), 32'(bus1.ext_gnt), 32'(g1_exp[c]));
      cmp($sformatf("starve mw1 stall c%0d", c), 32'(bus1.core_stall), 32'(s1_exp[c]));
      next_cycle();
    end
    idle_cycle();

    // MAX_WAIT=1 alternation with reads on both sides.
    g1_exp = 6'b101010; v1_exp = 6'b010100;
    contend_read();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmp($sformatf("alt gnt c%0d", c), 32'(bus1.ext_gnt), 32'(g1_exp[c]));
      cmp($sformatf("alt stall c%0d", c), 32'(bus1.core_stall), 32'(g1_exp[c]));
      cmp($sformatf("alt rvalid c%0d", c), 32'(bus1.ext_rvalid), 32'(v1_exp[c]));
      if (c == 2) cmp("alt rdata", bus1.ext_rdata, 32'h12345678);
      next_cycle();
    end
    idle_cycle();

    // Forced slot with ext request withdrawn: idle slot, core still stalled, count restarts.
    for (int c = 0; c < 10; c++) begin
      contend_read();
      if (c == 4) ext_req = 1'b0;
      @(negedge clk);
      if (c == 4) begin
        cmp("drop mem_rd", 32'(bus0.mem_rd), 32'd0);
        cmp("drop mem_wr", 32'(bus0.mem_wr), 32'd0);
        cmp("drop stall", 32'(bus0.core_stall), 32'd1);
      end
      if (c >= 5) begin
        cmp($sformatf("drop regrant c%0d", c), 32'(bus0.ext_gnt), 32'(c == 9));
        cmp($sformatf("drop restall c%0d", c), 32'(bus0.core_stall), 32'(c == 9));
      end
      next_cycle();
    end
    idle_cycle();

    // Reset landing on the forced slot.
    for (int c = 0; c < 6; c++) begin
      contend_read();
      reset = (c == 4);
      @(negedge clk);
      if (c == 4) cmp("rst force gnt", 32'(bus0.ext_gnt), 32'd1);
      if (c == 5) begin
        cmp("rst after stall", 32'(bus0.core_stall), 32'd0);
        cmp("rst after gnt", 32'(bus0.ext_gnt), 32'd0);
        cmp("rst after rvalid", 32'(bus0.ext_rvalid), 32'd0);
        cmp("rst after rdata", bus0.ext_rdata, 32'h0);
      end
      next_cycle();
    end
    reset = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r           = $urandom_range(0, 3);
      reset       = ($urandom_range(0, 99) == 0);
      core_rd     = (r == 1) || (r == 3);
      core_wr     = (r == 2);
      core_addr   = 9'($urandom_range(0, 127) << 2);
      core_wdata  = $urandom;
      core_funct3 = 3'($urandom_range(0, 7));
      ext_req     = ($urandom_range(0, 2) != 0);
      ext_we      = 1'($urandom_range(0, 1));
      ext_addr    = 9'($urandom_range(0, 127) << 2);
      ext_wdata   = $urandom;
      next_cycle();
    end
    reset = 1'b0;
    idle_cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between the pipeline MEM stage (core) and an external debug/loader master (ext).
- Core has priority.
- A starvation counter forces an ext slot after MAX_WAIT consecutive blocked cycles. The core is then stalled for that one cycle.
- Sits between the EX/MEM pipeline register outputs and the data memory instance. Drives a stall into the pipeline hazard logic.

Parameters:
DATA_W, 32, data width
DM_ADDRESS, 9, data memory byte-address width
MAX_WAIT, 4, consecutive denied ext cycles before a forced ext grant (1..15)
CNT_W, 4, width of wait counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_rd  in  1  MEM-stage read request
core_wr  in  1  MEM-stage write request
core_addr  in  DM_ADDRESS  core address
core_wdata  in  DATA_W  core store data
core_funct3  in  3  core access size/sign
core_stall  out  1  core access not performed this cycle; hold pipeline
core_rdata  out  DATA_W  core load data (combinational, same cycle as grant)
ext_req  in  1  ext access request, held until ext_gnt
ext_we  in  1  ext write (1) / read (0)
ext_addr  in  DM_ADDRESS  ext address
ext_wdata  in  DATA_W  ext write data
ext_gnt  out  1  ext access performed this cycle
ext_rvalid  out  1  ext read data valid (cycle after grant)
ext_rdata  out  DATA_W  registered ext read data
mem_rd  out  1  to memory
mem_wr  out  1  to memory
mem_addr  out  DM_ADDRESS  to memory
mem_wdata  out  DATA_W  to memory
mem_funct3  out  3  to memory
mem_rdata  in  DATA_W  memory read data (combinational read)

Behaviour:
- core_act = core_rd | core_wr. Memory write occurs at the clk edge; read data is combinational.
- Arbiter states:
  - CORE_PRI (reset state)
  - EXT_FORCE
- CORE_PRI:
  - core_act=1: core owns the port; ext_gnt=0.
  - core_act=0 and ext_req=1: ext owns the port; ext_gnt=1.
- Wait counter wcnt (CNT_W bits, reset 0):
  - Increments when ext_req & core_act in CORE_PRI.
  - Clears on any ext_gnt, or when ext_req=0.
  - If wcnt reaches MAX_WAIT-1 while incrementing, next state is EXT_FORCE and wcnt clears.
- EXT_FORCE (exactly one cycle):
  - ext owns the port; ext_gnt=ext_req.
  - core_stall=core_act.
  - Next state is CORE_PRI unconditionally.
  - If ext_req dropped, the slot is idle (mem_rd=mem_wr=0) and core_stall still = core_act.
- core_stall=0 in CORE_PRI. The core is never stalled twice in a row by the arbiter.
- Memory mux:
  - Core owner: passes core_* fields.
  - Ext owner: mem_rd=~ext_we, mem_wr=ext_we, mem_funct3=3'b010 (word).
  - No owner: mem_rd=mem_wr=0; addr, wdata, funct3 = core values.
- core_rdata = mem_rdata at all times. Valid only when core_rd & ~core_stall.
- ext read return: ext_rdata <= mem_rdata and ext_rvalid <= 1 at the edge ending a granted ext read. Otherwise ext_rvalid <= 0; ext_rdata holds.
- Simultaneous core_act and ext_req with wcnt < MAX_WAIT-1: core wins.
- MAX_WAIT=1: every contested cycle alternates core then ext.
- Reset values:
  - state=CORE_PRI, wcnt=0, ext_rvalid=0, ext_rdata=0.
  - Combinational outputs follow from inputs: core_stall=0; ext_gnt=ext_req&~core_act.
- Reset asserted mid-EXT_FORCE: the forced slot is abandoned at the next edge. An ext write in that cycle is still issued combinationally. ext master must re-request after reset.
- ext_req deasserted without grant: no access; counter clears.

Decomposition:
- Shared package dmem_arb_pkg:
  - arb_state_e enum {CORE_PRI, EXT_FORCE}
  - constant FUNCT3_WORD=3'b010
  - dmem_req_t struct {rd, wr, addr, wdata, funct3} used for both masters and the memory side.
- One natural sub-module: dmem_req_mux, the owner-select mux of dmem_req_t.

Test Plan:
- Reset high 2 cycles, then core_rd at addr 0x10 (mem holds 0xDEADBEEF), no ext → core_stall=0, core_rdata=0xDEADBEEF same cycle, ext_gnt=0.
- Core idle, ext_req write 0x20=0x12345678, then ext read 0x20 → ext_gnt=1 both cycles; ext_rvalid=1 with ext_rdata=0x12345678 on the cycle after the read grant.
- MAX_WAIT=4, core_wr every cycle, ext_req held from cycle 0 → ext_gnt=0 cycles 0-3, ext_gnt=1 and core_stall=1 cycle 4, core resumes cycle 5 with core_stall=0.
- MAX_WAIT=1, core_rd and ext_req continuous → ext_gnt/core_stall toggle 0,1,0,1; ext_rvalid pulses every other cycle.
- Forced state reached, ext_req dropped same cycle → mem_rd=mem_wr=0, core_stall=1 for one cycle, wcnt=0 afterward.
- Reset asserted during EXT_FORCE → next cycle state CORE_PRI, ext_rvalid=0, ext_rdata=0, core_stall=0.
